// File: rtl/tetron_move_ctrl_if.sv
// Bundle of request, shaper, board-read and piece-status signals around tetron_move_ctrl.
// The slave modport is the controller side; master is the environment driving requests.
// No storage or latency of its own; req_ready gives the backpressure.
interface tetron_move_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic        req_ready;
    logic        shp_active;
    logic [2:0]  shp_rotation;
    logic [19:0] shp_voff;
    logic [19:0] shp_hoff;
    logic        brd_rd_en;
    logic [4:0]  brd_rd_row;
    logic [3:0]  brd_rd_col;
    logic        brd_rd_occ;
    logic [4:0]  piece_row;
    logic [3:0]  piece_col;
    logic [2:0]  piece_rot;
    logic        piece_live;
    logic        done_valid;
    logic        done_ok;
    logic        lock;
    logic        game_over;

    modport slave (
        input  req_valid, req_op, shp_voff, shp_hoff, brd_rd_occ,
        output req_ready, shp_active, shp_rotation, brd_rd_en, brd_rd_row, brd_rd_col,
               piece_row, piece_col, piece_rot, piece_live, done_valid, done_ok, lock, game_over
    );

    modport master (
        output req_valid, req_op, shp_voff, shp_hoff, brd_rd_occ,
        input  req_ready, shp_active, shp_rotation, brd_rd_en, brd_rd_row, brd_rd_col,
               piece_row, piece_col, piece_rot, piece_live, done_valid, done_ok, lock, game_over
    );
endinterface

// File: rtl/tetron_move_ctrl.sv
// Falling-piece move sequencer: probes four candidate cells on the board, then commits or rejects.
// Latency 7 cycles handshake-to-done (1 on early reject; up to 17 with TETRON_WALL_KICK_EN defined).
// One request in flight; req_ready is high only in IDLE.
module tetron_move_ctrl #(
    parameter int BOARD_W   = 10,
    parameter int BOARD_H   = 20,
    parameter int SPAWN_COL = 4,
    parameter int SPAWN_ROW = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    tetron_move_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SHAPE, PROBE1, PROBE2, PROBE3, PROBE4, DECIDE, DONE} state_t;

    localparam logic [2:0] OP_LEFT  = 3'd0;
    localparam logic [2:0] OP_RIGHT = 3'd1;
    localparam logic [2:0] OP_DOWN  = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_SPAWN = 3'd4;
    localparam logic signed [6:0] W7 = 7'(BOARD_W);
    localparam logic signed [6:0] H7 = 7'(BOARD_H);

    state_t            state, state_nx;
    logic        [4:0] row_q;
    logic        [3:0] col_q;
    logic        [1:0] rot_q, shp_rot_q, cand_rot;
    logic signed [6:0] cand_row, cand_col;
    logic        [2:0] op_q;
    logic              live_q, over_q, collide_q, rd_pend_q, ok_q, lock_q;

    logic              handshake, reject, oob, collide_all;
    logic signed [6:0] row_ext, col_ext, nx_row, nx_col, cell_row, cell_col;
    logic        [1:0] nx_rot;
    logic        [4:0] voff, hoff;

`ifdef TETRON_WALL_KICK_EN
    logic [1:0] kick_q;
    logic       kick_retry;
    assign kick_retry = (state == DECIDE) && collide_all && (op_q == OP_ROT) && (kick_q != 2'd2);
`endif

    assign row_ext     = {2'b00, row_q};
    assign col_ext     = {3'b000, col_q};
    assign handshake   = bus.req_valid && (state == IDLE);
    assign reject      = (bus.req_op > OP_SPAWN) || over_q ||
                         ((bus.req_op == OP_SPAWN) ? live_q : !live_q);
    // Occupancy returned this cycle belongs to the read issued in the previous probe.
    assign collide_all = collide_q || (rd_pend_q && bus.brd_rd_occ);

    always_comb begin
        nx_row = row_ext;
        nx_col = col_ext;
        nx_rot = rot_q;
        case (bus.req_op)
            OP_LEFT:  nx_col = col_ext - 7'sd1;
            OP_RIGHT: nx_col = col_ext + 7'sd1;
            OP_DOWN:  nx_row = row_ext + 7'sd1;
            OP_ROT:   nx_rot = rot_q + 2'd1;
            OP_SPAWN: begin
                nx_row = 7'(SPAWN_ROW);
                nx_col = 7'(SPAWN_COL);
                nx_rot = 2'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        voff = 5'd0;
        hoff = 5'd0;
        case (state)
            PROBE1: begin voff = bus.shp_voff[4:0];   hoff = bus.shp_hoff[4:0];   end
            PROBE2: begin voff = bus.shp_voff[9:5];   hoff = bus.shp_hoff[9:5];   end
            PROBE3: begin voff = bus.shp_voff[14:10]; hoff = bus.shp_hoff[14:10]; end
            PROBE4: begin voff = bus.shp_voff[19:15]; hoff = bus.shp_hoff[19:15]; end
            default: ;
        endcase
        cell_row = cand_row + {{2{voff[4]}}, voff};
        cell_col = cand_col + {{2{hoff[4]}}, hoff};
        oob      = (cell_row < 7'sd0) || (cell_row >= H7) || (cell_col < 7'sd0) || (cell_col >= W7);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (handshake) state_nx = reject ? DONE : SHAPE;
            SHAPE:  state_nx = PROBE1;
            PROBE1: state_nx = PROBE2;
            PROBE2: state_nx = PROBE3;
            PROBE3: state_nx = PROBE4;
            PROBE4: state_nx = DECIDE;
            DECIDE: begin
                state_nx = DONE;
`ifdef TETRON_WALL_KICK_EN
                if (kick_retry) state_nx = PROBE1;
`endif
            end
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= 5'(SPAWN_ROW);
            col_q     <= 4'(SPAWN_COL);
            rot_q     <= 2'd0;
            shp_rot_q <= 2'd0;
            cand_row  <= '0;
            cand_col  <= '0;
            cand_rot  <= 2'd0;
            op_q      <= 3'd0;
            live_q    <= 1'b0;
            over_q    <= 1'b0;
            collide_q <= 1'b0;
            rd_pend_q <= 1'b0;
            ok_q      <= 1'b0;
            lock_q    <= 1'b0;
`ifdef TETRON_WALL_KICK_EN
            kick_q    <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: if (handshake) begin
                    op_q      <= bus.req_op;
                    cand_row  <= nx_row;
                    cand_col  <= nx_col;
                    cand_rot  <= nx_rot;
                    ok_q      <= 1'b0;
                    lock_q    <= 1'b0;
                    collide_q <= 1'b0;
                    rd_pend_q <= 1'b0;
`ifdef TETRON_WALL_KICK_EN
                    kick_q    <= 2'd0;
`endif
                    if (!reject) shp_rot_q <= nx_rot;
                end
                PROBE1, PROBE2, PROBE3, PROBE4: begin
                    collide_q <= collide_all || oob;
                    rd_pend_q <= !oob;
                end
                DECIDE: begin
                    rd_pend_q <= 1'b0;
`ifdef TETRON_WALL_KICK_EN
                    if (kick_retry) begin
                        kick_q    <= kick_q + 2'd1;
                        collide_q <= 1'b0;
                        cand_col  <= (kick_q == 2'd0) ? col_ext - 7'sd1 : col_ext + 7'sd1;
                    end else
`endif
                    if (!collide_all) begin
                        ok_q  <= 1'b1;
                        row_q <= cand_row[4:0];
                        col_q <= cand_col[3:0];
                        rot_q <= cand_rot;
                        if (op_q == OP_SPAWN) live_q <= 1'b1;
                    end else if (op_q == OP_DOWN) begin
                        lock_q <= 1'b1;
                        live_q <= 1'b0;
                    end else if (op_q == OP_SPAWN) begin
                        over_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.shp_active   = live_q || ((op_q == OP_SPAWN) && (state inside {SHAPE, PROBE1, PROBE2, PROBE3, PROBE4, DECIDE}));
    assign bus.shp_rotation = {1'b0, shp_rot_q};
    assign bus.brd_rd_en    = (state inside {PROBE1, PROBE2, PROBE3, PROBE4}) && !oob;
    assign bus.brd_rd_row   = bus.brd_rd_en ? cell_row[4:0] : 5'd0;
    assign bus.brd_rd_col   = bus.brd_rd_en ? cell_col[3:0] : 4'd0;
    assign bus.piece_row    = row_q;
    assign bus.piece_col    = col_q;
    assign bus.piece_rot    = {1'b0, rot_q};
    assign bus.piece_live   = live_q;
    assign bus.game_over    = over_q;
    assign bus.done_valid   = (state == DONE);
    assign bus.done_ok      = (state == DONE) && ok_q;
    assign bus.lock         = (state == DONE) && lock_q;
endmodule

// File: tb/tb_tetron_move_ctrl.sv
// Directed bench for tetron_move_ctrl: board memory model, static shaper, expectation scoreboard.
module tb_tetron_move_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tetron_move_ctrl_if bus();
    tetron_move_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic       ok;
        logic       lock;
        int         lat;
        logic [4:0] row;
        logic [3:0] col;
        logic [2:0] rot;
        logic       live;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic       board [0:31][0:15];
    logic [8:0] rd_log [0:255];
    int         rd_n = 0;
    logic [2:0] rot_at_shape;
    logic       act_at_shape;
    int         base;

    // Board memory: occupancy answers one cycle after the read strobe.
    always @(posedge clk) begin
        bus.brd_rd_occ <= (bus.brd_rd_en === 1'b1) ? board[bus.brd_rd_row][bus.brd_rd_col] : 1'b0;
        if (bus.brd_rd_en === 1'b1 && rd_n < 256) begin
            rd_log[rd_n] <= {bus.brd_rd_row, bus.brd_rd_col};
            rd_n <= rd_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic ok, input logic lk, input int lat, input logic [4:0] row,
                                input logic [3:0] col, input logic [2:0] rot, input logic live);
        exp_t e;
        e.ok = ok; e.lock = lk; e.lat = lat; e.row = row; e.col = col; e.rot = rot; e.live = live;
        return e;
    endfunction

    task automatic run_req(input string tag, input logic [2:0] op, input exp_t e);
        exp_t g;
        int   lat;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        rot_at_shape = bus.shp_rotation;
        act_at_shape = bus.shp_active;
        check({tag, "_busy"}, bus.req_ready, 1'b0);
        while (bus.done_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        g = sb.pop_front();
        check({tag, "_done"}, bus.done_valid, 1'b1);
        check({tag, "_lat"},  lat,            g.lat);
        check({tag, "_ok"},   bus.done_ok,    g.ok);
        check({tag, "_lock"}, bus.lock,       g.lock);
        check({tag, "_row"},  bus.piece_row,  g.row);
        check({tag, "_col"},  bus.piece_col,  g.col);
        check({tag, "_rot"},  bus.piece_rot,  g.rot);
        check({tag, "_live"}, bus.piece_live, g.live);
        @(posedge clk); #1;
        check({tag, "_ready"}, bus.req_ready, 1'b1);
        check({tag, "_pulse"}, bus.done_valid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.req_ready,    1'b1);
        check({tag, "_row"},   bus.piece_row,    5'd0);
        check({tag, "_col"},   bus.piece_col,    4'd4);
        check({tag, "_rot"},   bus.piece_rot,    3'd0);
        check({tag, "_live"},  bus.piece_live,   1'b0);
        check({tag, "_over"},  bus.game_over,    1'b0);
        check({tag, "_done"},  bus.done_valid,   1'b0);
        check({tag, "_rden"},  bus.brd_rd_en,    1'b0);
        check({tag, "_act"},   bus.shp_active,   1'b0);
        check({tag, "_shrot"}, bus.shp_rotation, 3'd0);
    endtask

    task automatic clear_board();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 16; c++)
                board[r][c] = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        // Blocks (v,h): (0,0) (0,+1) (0,-1) (+1,-1), packed {blk4,blk3,blk2,blk1}.
        bus.shp_voff  = {5'd1, 5'd0, 5'd0, 5'd0};
        bus.shp_hoff  = {5'h1F, 5'h1F, 5'd1, 5'd0};
        clear_board();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;

        run_req("left_dead", 3'd0, mk(0, 0, 1, 5'd0, 4'd4, 3'd0, 0));
        run_req("bad_op",    3'd6, mk(0, 0, 1, 5'd0, 4'd4, 3'd0, 0));

        base = rd_n;
        run_req("spawn", 3'd4, mk(1, 0, 7, 5'd0, 4'd4, 3'd0, 1));
        check("spawn_act", act_at_shape, 1'b1);
        check("spawn_nrd", rd_n - base, 4);
        check("spawn_rd1", rd_log[base],     {5'd0, 4'd4});
        check("spawn_rd2", rd_log[base + 1], {5'd0, 4'd5});
        check("spawn_rd3", rd_log[base + 2], {5'd0, 4'd3});
        check("spawn_rd4", rd_log[base + 3], {5'd1, 4'd3});
        run_req("spawn_live", 3'd4, mk(0, 0, 1, 5'd0, 4'd4, 3'd0, 1));

        run_req("right5", 3'd1, mk(1, 0, 7, 5'd0, 4'd5, 3'd0, 1));
        run_req("right6", 3'd1, mk(1, 0, 7, 5'd0, 4'd6, 3'd0, 1));
        run_req("right7", 3'd1, mk(1, 0, 7, 5'd0, 4'd7, 3'd0, 1));
        run_req("right8", 3'd1, mk(1, 0, 7, 5'd0, 4'd8, 3'd0, 1));
        base = rd_n;
        run_req("right_wall", 3'd1, mk(0, 0, 7, 5'd0, 4'd8, 3'd0, 1));
        check("wall_nrd", rd_n - base, 3);

        run_req("rot1", 3'd3, mk(1, 0, 7, 5'd0, 4'd8, 3'd1, 1));
        check("rot1_shape", rot_at_shape, 3'd1);
        run_req("rot2", 3'd3, mk(1, 0, 7, 5'd0, 4'd8, 3'd2, 1));
        run_req("rot3", 3'd3, mk(1, 0, 7, 5'd0, 4'd8, 3'd3, 1));
        run_req("rot0", 3'd3, mk(1, 0, 7, 5'd0, 4'd8, 3'd0, 1));
        check("rot0_shape", rot_at_shape, 3'd0);

        run_req("down1", 3'd2, mk(1, 0, 7, 5'd1, 4'd8, 3'd0, 1));
        board[3][7] = 1'b1;
        run_req("down_lock", 3'd2, mk(0, 1, 7, 5'd1, 4'd8, 3'd0, 0));
        run_req("left_locked", 3'd0, mk(0, 0, 1, 5'd1, 4'd8, 3'd0, 0));

        board[0][5] = 1'b1;
        run_req("spawn_blk", 3'd4, mk(0, 0, 7, 5'd1, 4'd8, 3'd0, 0));
        check("game_over", bus.game_over, 1'b1);
        board[0][5] = 1'b0;
        run_req("spawn_over", 3'd4, mk(0, 0, 1, 5'd1, 4'd8, 3'd0, 0));
        check("game_over_hold", bus.game_over, 1'b1);

        @(negedge clk) rst_n = 1'b0;
        clear_board();
        @(negedge clk) rst_n = 1'b1;
        run_req("spawn2", 3'd4, mk(1, 0, 7, 5'd0, 4'd4, 3'd0, 1));

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("p2_rden", bus.brd_rd_en, 1'b1);
        check("p2_col",  bus.brd_rd_col, 4'd6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_nodone", bus.done_valid, 1'b0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", bus.req_ready, 1'b1);
        check("abort_live",  bus.piece_live, 1'b0);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tetron_move_ctrl.md
# tetron_move_ctrl

Sequencer for the active falling piece. Accepts one move request at a time (left, right, down, rotate, spawn) and drives the piece shaper with the candidate rotation. It probes the board occupancy memory for all four candidate block cells and commits or rejects the move. It sits between the input/gravity logic and the board/render logic, and owns the live piece's row, column and rotation.

## Interface
Parameters:
- BOARD_W, 10, board width in cells (≤16)
- BOARD_H, 20, board height in cells (≤32)
- SPAWN_COL, 4, column of block 1 on spawn
- SPAWN_ROW, 0, row of block 1 on spawn

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_op  in  3  0=left, 1=right, 2=down, 3=rotate CW, 4=spawn; 5–7 are illegal
- req_ready  out  1  high only in IDLE
- shp_active  out  1  shaper enable; high whenever piece_live or a spawn is in flight
- shp_rotation  out  3  candidate rotation driven to the shaper (0..3)
- shp_voff  in  20  {blk4,blk3,blk2,blk1} vertical offsets, 5-bit two's complement, registered by the shaper
- shp_hoff  in  20  horizontal offsets, same packing
- brd_rd_en  out  1  board read strobe
- brd_rd_row  out  5  cell row (0 = top)
- brd_rd_col  out  4  cell column
- brd_rd_occ  in  1  occupancy; valid exactly 1 cycle after brd_rd_en
- piece_row / piece_col / piece_rot  out  5/4/3  committed block-1 position and rotation
- piece_live  out  1  a piece is active
- done_valid  out  1  one-cycle pulse when a request completes
- done_ok  out  1  move committed; valid with done_valid
- lock  out  1  one-cycle pulse with done_valid when a down move is rejected
- game_over  out  1  sticky; set on a failed spawn

## Operation
- States: IDLE, SHAPE, PROBE1–PROBE4, DECIDE, DONE.
- IDLE: a handshake occurs when req_valid && req_ready. On handshake, load the candidate row/col/rot:
  - left: col−1
  - right: col+1
  - down: row+1
  - rotate: (rot+1) mod 4, so 3 wraps to 0
  - spawn: SPAWN_ROW, SPAWN_COL, rot 0
- Any request other than spawn while piece_live=0, any spawn while piece_live=1, any illegal op, or any request while game_over=1: go straight to DONE with done_ok=0. No board reads occur.
- SHAPE: shp_rotation = candidate rotation. This state is one wait cycle for the shaper's register.
- PROBE k:
  - Cell = candidate position + sign-extended offset of block k. Compute in 7-bit signed arithmetic.
  - If the cell is out of bounds (row<0, row≥BOARD_H, col<0, col≥BOARD_W): brd_rd_en=0 and block k is marked colliding.
  - Otherwise brd_rd_en=1, and brd_rd_occ sampled in the next cycle is ORed into the collide flag.
- DECIDE: sample the block-4 occupancy.
  - No collision: commit the candidate to piece_*, done_ok=1. A spawn sets piece_live.
  - Collision on down: lock=1, piece_live←0.
  - Collision on spawn: game_over←1.
  - Collision otherwise: piece unchanged.
- DONE: done_valid=1 for one cycle, then return to IDLE. The piece_* outputs already show the committed values in this cycle.
- When shp_active=0, shp_rotation holds its value and the shaper outputs are ignored.

## Timing
- Reset values:
  - state IDLE
  - req_ready=1
  - piece_row=SPAWN_ROW, piece_col=SPAWN_COL, piece_rot=0
  - piece_live=0, game_over=0
  - done_valid=0, done_ok=0, lock=0
  - brd_rd_en=0, brd_rd_row=0, brd_rd_col=0
  - shp_active=0, shp_rotation=0
- Handshake edge = cycle 0. Then: SHAPE in cycle 1, PROBE1–4 in cycles 2–5, DECIDE in cycle 6, DONE in cycle 7. Fixed latency is 7 cycles, or 1 cycle for the early-reject path.
- At most one request is in flight. req_ready=0 from cycle 1 until DONE, inclusive. Requests are back-to-back at 8 cycles.
- rst_n asserted mid-operation aborts the request immediately. No done pulse is emitted, and all registers take their reset values.
- Probe reads are issued even when an earlier block has already collided; timing is data-independent.

## Configuration
- TETRON_WALL_KICK_EN:
  - Defined: a rotate rejected in DECIDE retries PROBE1–4 + DECIDE with candidate col−1, then col+1, before giving up. Rotation is unchanged, so the shaper output is reused. Each retry adds 5 cycles (max latency 17). A kicked commit updates piece_col.
  - Undefined: a rejected rotate completes with done_ok=0 at cycle 7.

## Test plan
- Spawn on an empty board, shaper offsets (0,0),(0,1),(0,−1),(1,−1) → reads at (0,4),(0,5),(0,3),(1,3); done at cycle 7; done_ok=1; piece_live=1; row 0, col 4.
- Repeated right from col 4 with the same shape → the commit at col 8 succeeds; the next right is rejected (block 2 at col 10), done_ok=0, col stays 8.
- Down with brd_rd_occ=1 on the block-4 read → lock pulse with done_valid; piece_live=0; a following left completes at cycle 1 with done_ok=0.
- Spawn with an occupied cell → game_over=1, done_ok=0; a later spawn is rejected at cycle 1.
- Rotate from rot 3 on an open board → shp_rotation=0 during SHAPE; piece_rot=0 after DONE.
- rst_n low during PROBE2 → no done_valid; all outputs at reset values; req_ready=1 one cycle after release.
